// File: rtl/hgcal_fc_counter_readout_pkg.sv
// Shared definitions for the fast-command counter readout block:
// FSM encoding, the invalid-read marker and the status-word layout.
package hgcal_fc_counter_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SNAP      = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_READ      = 3'd3,
    ST_WAIT_DROP = 3'd4
  } state_e;

  localparam logic [31:0] INVALID_RD_DATA      = 32'hDEAD_BEEF;
  localparam int          STATUS_PEND_CLR_BIT  = 31;
  localparam int          STATUS_PEND_SNAP_BIT = 30;
  localparam int          SNAP_COUNT_W         = 16;

  // The status word sits immediately above the last counter address.
  function automatic logic [3:0] status_addr(input int ncounters);
    return 4'(ncounters);
  endfunction

  function automatic logic [31:0] status_word(input logic pend_clr,
                                              input logic pend_snap,
                                              input logic [SNAP_COUNT_W-1:0] snap_cnt);
    logic [31:0] w;
    w = '0;
    w[STATUS_PEND_CLR_BIT]    = pend_clr;
    w[STATUS_PEND_SNAP_BIT]   = pend_snap;
    w[SNAP_COUNT_W-1:0]       = snap_cnt;
    return w;
  endfunction

endpackage

// File: rtl/hgcal_fc_counter_readout_if.sv
// Read bus between a slow-control master and the counter readout block.
interface hgcal_fc_counter_readout_if;
  logic        rd_strobe;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        rd_err;

  modport slave  (input  rd_strobe, rd_addr, output rd_data, rd_ack, rd_err);
  modport master (output rd_strobe, rd_addr, input  rd_data, rd_ack, rd_err);
endinterface

// File: rtl/hgcal_fc_readout_shadow.sv
// Shadow register bank loaded in one shot on snapshot, plus the read address mux
// (shadow / status word / invalid marker with error flag).
module hgcal_fc_readout_shadow
  import hgcal_fc_counter_readout_pkg::*;
#(
  parameter int NCOUNTERS = 8
) (
  input  logic                    clk_io,
  input  logic                    rst_n,
  input  logic                    snap_load_i,
  input  logic [NCOUNTERS*32-1:0] counters_i,
  input  logic [3:0]              addr_i,
  input  logic [31:0]             status_i,
  output logic [31:0]             data_o,
  output logic                    err_o
);

  logic [31:0] shadow_q [NCOUNTERS];

  always_ff @(posedge clk_io or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOUNTERS; i++) shadow_q[i] <= '0;
    end else if (snap_load_i) begin
      for (int i = 0; i < NCOUNTERS; i++) shadow_q[i] <= counters_i[32*i +: 32];
    end
  end

  always_comb begin
    data_o = INVALID_RD_DATA;
    err_o  = 1'b1;
    if (addr_i == status_addr(NCOUNTERS)) begin
      data_o = status_i;
      err_o  = 1'b0;
    end
    for (int i = 0; i < NCOUNTERS; i++) begin
      if (addr_i == 4'(i)) begin
        data_o = shadow_q[i];
        err_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hgcal_fc_counter_readout.sv
// Snapshot/clear/readout controller for up to 15 live 32-bit counters.
// Pending snap/clear requests are sticky and serviced from IDLE, snapshot first.
module hgcal_fc_counter_readout
  import hgcal_fc_counter_readout_pkg::*;
#(
  parameter int NCOUNTERS    = 8,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                      clk_io,
  input  logic                      reset_n,
  input  logic [NCOUNTERS*32-1:0]   counters_in,
  input  logic                      snap_req,
  input  logic                      clear_req,
  hgcal_fc_counter_readout_if.slave rd_if,
  output logic                      counter_reset,
  output logic                      busy
);

  // Reset asserts asynchronously, releases two clock edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_io or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                  state_q, state_d;
  logic                    pend_snap_q, pend_snap_d;
  logic                    pend_clr_q, pend_clr_d;
  logic [SNAP_COUNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic [7:0]              clr_cnt_q, clr_cnt_d;
  logic [3:0]              addr_q, addr_d;
  logic                    take_snap, take_clr, snap_load;
  logic [31:0]             mux_data;
  logic                    mux_err;

  always_ff @(posedge clk_io or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_snap_q <= 1'b0;
      pend_clr_q  <= 1'b0;
      snap_cnt_q  <= '0;
      clr_cnt_q   <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_snap_q <= pend_snap_d;
      pend_clr_q  <= pend_clr_d;
      snap_cnt_q  <= snap_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      addr_q      <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_cnt_d = snap_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    addr_d     = addr_q;
    take_snap  = 1'b0;
    take_clr   = 1'b0;
    snap_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_snap_q) begin
          state_d   = ST_SNAP;
          take_snap = 1'b1;
        end else if (pend_clr_q) begin
          state_d   = ST_CLEAR;
          take_clr  = 1'b1;
          clr_cnt_d = '0;
        end else if (rd_if.rd_strobe) begin
          state_d = ST_READ;
          addr_d  = rd_if.rd_addr;
        end
      end
      ST_SNAP: begin
        snap_load  = 1'b1;
        snap_cnt_d = snap_cnt_q + 16'd1;
        state_d    = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == 8'(CLEAR_CYCLES - 1)) state_d = ST_IDLE;
        else                                   clr_cnt_d = clr_cnt_q + 8'd1;
      end
      ST_READ:      state_d = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!rd_if.rd_strobe) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    // A pulse arriving while its flag is already set is simply absorbed.
    pend_snap_d = snap_req  | (pend_snap_q & ~take_snap);
    pend_clr_d  = clear_req | (pend_clr_q  & ~take_clr);
  end

  hgcal_fc_readout_shadow #(
    .NCOUNTERS (NCOUNTERS)
  ) u_shadow (
    .clk_io      (clk_io),
    .rst_n       (rst_n),
    .snap_load_i (snap_load),
    .counters_i  (counters_in),
    .addr_i      (addr_q),
    .status_i    (status_word(pend_clr_q, pend_snap_q, snap_cnt_q)),
    .data_o      (mux_data),
    .err_o       (mux_err)
  );

  assign counter_reset  = (state_q == ST_CLEAR);
  assign busy           = (state_q != ST_IDLE);
  assign rd_if.rd_ack   = (state_q == ST_READ);
  assign rd_if.rd_data  = rd_if.rd_ack ? mux_data : 32'd0;
  assign rd_if.rd_err   = rd_if.rd_ack & mux_err;

endmodule

// File: doc/hgcal_fc_counter_readout.md
HGCAL_FC_COUNTER_READOUT -- requirements
Module: hgcal_fc_counter_readout

Interface
REQ-001 SHALL have parameter NCOUNTERS, default 8, range 1..15: number of 32-bit counters served.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 4, range 1..255: width of counter_reset pulse, sized to span slower counting clocks.
REQ-003 SHALL have port clk_io, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port counters_in, input, NCOUNTERS*32: live counter values already in clk_io domain; counter i occupies bits [32i+31:32i].
REQ-006 SHALL have port snap_req, input, 1: one-cycle pulse requesting a snapshot of all counters.
REQ-007 SHALL have port clear_req, input, 1: one-cycle pulse requesting a counter clear.
REQ-008 SHALL have port rd_strobe, input, 1: level read request, held until rd_ack seen.
REQ-009 SHALL have port rd_addr, input, 4: read address, sampled when a read is accepted.
REQ-010 SHALL have port rd_data, output, 32: read data, valid while rd_ack=1.
REQ-011 SHALL have port rd_ack, output, 1: one-cycle read acknowledge.
REQ-012 SHALL have port rd_err, output, 1: asserted with rd_ack for an invalid address.
REQ-013 SHALL have port counter_reset, output, 1: active-high clear pulse to all counter instances.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, SNAP, CLEAR, READ, WAIT_DROP.
REQ-016 In IDLE, SHALL service in this priority: pending snapshot, then pending clear, then rd_strobe=1.
REQ-017 Simultaneous snap and clear SHALL run the snapshot first, so shadows hold pre-clear values.
REQ-018 snap_req and clear_req arriving in any state SHALL set sticky one-deep pending flags; further pulses while a flag is already set SHALL be absorbed.
REQ-019 Entering SNAP SHALL clear the snapshot pending flag.
REQ-020 SNAP SHALL last one cycle: all shadow registers load counters_in simultaneously; snap_count increments; then IDLE.
REQ-021 snap_count SHALL be 16 bits and wrap from 0xFFFF to 0x0000.
REQ-022 Entering CLEAR SHALL clear the clear pending flag.
REQ-023 In CLEAR, counter_reset SHALL be 1 for exactly CLEAR_CYCLES consecutive cycles, then return to IDLE.
REQ-024 Clear SHALL NOT alter shadow registers or snap_count.
REQ-025 Read acceptance SHALL latch rd_addr and go to READ.
REQ-026 In READ, rd_ack SHALL be 1 for one cycle, exactly one cycle after acceptance, then go to WAIT_DROP.
REQ-027 In WAIT_DROP, the block SHALL return to IDLE when rd_strobe=0; a read held high SHALL never be acknowledged twice.
REQ-028 Read address rules: addr < NCOUNTERS returns shadow[addr]; addr == NCOUNTERS returns status {pending_clear, pending_snap, 14'b0, snap_count}, with flags in bits 31/30; other addresses return 0xDEADBEEF with rd_err=1.
REQ-029 rd_data SHALL be 0 whenever rd_ack=0.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE, shadows=0, snap_count=0, pending flags=0, rd_ack=0, rd_err=0, rd_data=0, counter_reset=0, busy=0.
REQ-031 Reset during CLEAR SHALL terminate counter_reset immediately.
REQ-032 Reset during READ SHALL suppress the pending rd_ack.
REQ-033 Deassertion of reset_n SHALL be synchronized internally via a 2-flop synchronizer.

Structure
REQ-034 A shared package SHALL hold the state encoding, the STATUS_ADDR rule (=NCOUNTERS), the invalid-read constant 0xDEADBEEF and the status-word bit positions.
REQ-035 One sub-module, hgcal_fc_readout_shadow, SHALL hold the shadow register bank and the address mux.

Verification
REQ-036 Snapshot and read: counters_in[1]=0x12345678, snap_req pulse, read addr 1 -> rd_data=0x12345678, rd_ack 1 cycle after accept; status read -> snap_count=1.
REQ-037 Simultaneous snap and clear: counters_in[0]=0xAA, snap_req+clear_req same cycle -> shadow[0]=0xAA, then counter_reset high exactly 4 cycles.
REQ-038 Invalid read: NCOUNTERS=8, read addr 9 -> rd_data=0xDEADBEEF, rd_err=1; read addr 8 -> status word, rd_err=0.
REQ-039 Pending during read: clear_req while in WAIT_DROP with rd_strobe held 10 cycles -> status bit31=1 if read then; clear executes after strobe drops; single rd_ack.
REQ-040 Wrap and reset: 65536 snaps -> snap_count=0; reset_n low mid-CLEAR -> counter_reset low same cycle, all outputs at reset values.
